// File: rtl/pipeline_pkg.sv
// Shared opcodes, multiply/divide FSM states and EX/MEM bundle
// for the execute stage.
package pipeline_pkg;

  localparam int MD_CYCLES = 32;

  localparam logic [5:0] ALU_SLL   = 6'h00;
  localparam logic [5:0] ALU_SRL   = 6'h02;
  localparam logic [5:0] ALU_MFHI  = 6'h10;
  localparam logic [5:0] ALU_MFLO  = 6'h12;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;
  localparam logic [5:0] ALU_ADD   = 6'h20;
  localparam logic [5:0] ALU_SUB   = 6'h22;
  localparam logic [5:0] ALU_AND   = 6'h24;
  localparam logic [5:0] ALU_OR    = 6'h25;
  localparam logic [5:0] ALU_XOR   = 6'h26;
  localparam logic [5:0] ALU_NOR   = 6'h27;
  localparam logic [5:0] ALU_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [7:0]  branch_target;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  write_reg;
    logic        branch;
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_mem_t;

  function automatic logic is_md_op(input logic [5:0] op);
    return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative multiply/divide unit: shift-add multiplier and
// restoring divider sharing one 64-bit working register, plus HI/LO.
module muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int MD_CYCLES = pipeline_pkg::MD_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  alu_op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [63:0] p_q, p_d;
  logic        div_q, div_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start, is_div, is_signed;
  logic [31:0] mag1, mag2;
  logic [32:0] add_sum, rem_sh, rem_df;
  logic [63:0] step, prod;
  logic [31:0] quo, rem;

  always_comb begin
    is_div    = alu_op inside {ALU_DIV, ALU_DIVU};
    is_signed = alu_op inside {ALU_MULT, ALU_DIV};
    mag1 = (is_signed && data1[31]) ? -data1 : data1;
    mag2 = (is_signed && data2[31]) ? -data2 : data2;
    start = (state_q == MD_IDLE) && is_md_op(alu_op) && !flush;
    stall = !reset && (start || (state_q == MD_BUSY));

    // p_q holds {acc, multiplier} or {remainder, dividend}
    add_sum = {1'b0, p_q[63:32]} + {1'b0, (p_q[0] ? a_q : 32'd0)};
    rem_sh  = {p_q[63:32], p_q[31]};
    rem_df  = rem_sh - {1'b0, a_q};
    if (div_q)
      step = rem_df[32] ? {rem_sh[31:0], p_q[30:0], 1'b0}
                        : {rem_df[31:0], p_q[30:0], 1'b1};
    else
      step = {add_sum, p_q[31:1]};
    prod = (sa_q ^ sb_q) ? -step : step;
    quo  = (sa_q ^ sb_q) ? -step[31:0] : step[31:0];
    rem  = sa_q ? -step[63:32] : step[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = '0;
          div_d   = is_div;
          sa_d    = is_signed & data1[31];
          sb_d    = is_signed & data2[31];
          a_d     = is_div ? mag2 : mag1;
          p_d     = {32'd0, (is_div ? mag1 : mag2)};
        end
      end
      MD_BUSY: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          p_d   = step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(MD_CYCLES - 1)) begin
            state_d = MD_DONE;
            if (div_q) begin
              hi_d = rem;
              lo_d = (a_q == 32'd0) ? 32'hFFFF_FFFF : quo;
            end else begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, operand/destination muxes and the EX/MEM
// register; multiply/divide delegated to muldiv_unit.
module ex_stage
  import pipeline_pkg::*;
#(
  parameter int MD_CYCLES = pipeline_pkg::MD_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  alu_op,
  input  logic        reg_dst,
  input  logic        alu_src,
  input  logic        branch,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic [7:0]  pc_next,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] sign_extend,
  input  logic [4:0]  reg1,
  input  logic [4:0]  reg2,
  input  logic        flush_ex,
  output logic        stall_ex,
  output logic [7:0]  branch_target_reg,
  output logic        zero_reg,
  output logic [31:0] alu_result_reg,
  output logic [31:0] store_data_reg,
  output logic [4:0]  write_reg_reg,
  output logic        branch_reg,
  output logic        mem_write_reg,
  output logic        mem_read_reg,
  output logic        reg_write_reg,
  output logic        mem_to_reg_reg
);

  logic [31:0] hi, lo;
  logic [31:0] op_b, alu_res;
  logic [4:0]  shamt;
  logic        bubble;
  ex_mem_t     ex_mem_q, ex_mem_d;

  muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .alu_op (alu_op),
    .data1  (data1),
    .data2  (data2),
    .flush  (flush_ex),
    .stall  (stall_ex),
    .hi     (hi),
    .lo     (lo)
  );

  always_comb begin
    op_b  = alu_src ? sign_extend : data2;
    shamt = sign_extend[10:6];
    case (alu_op)
      ALU_ADD:  alu_res = data1 + op_b;
      ALU_SUB:  alu_res = data1 - op_b;
      ALU_AND:  alu_res = data1 & op_b;
      ALU_OR:   alu_res = data1 | op_b;
      ALU_XOR:  alu_res = data1 ^ op_b;
      ALU_NOR:  alu_res = ~(data1 | op_b);
      ALU_SLT:  alu_res = {31'd0, ($signed(data1) < $signed(op_b))};
      ALU_SLL:  alu_res = data2 << shamt;
      ALU_SRL:  alu_res = data2 >> shamt;
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = 32'd0;
    endcase
  end

  // multiply/divide ops retire as bubbles even once the unit is done
  always_comb begin
    bubble   = flush_ex | stall_ex | is_md_op(alu_op);
    ex_mem_d = '0;
    if (!bubble) begin
      ex_mem_d.branch_target = pc_next + sign_extend[7:0];
      ex_mem_d.zero          = (alu_res == 32'd0);
      ex_mem_d.alu_result    = alu_res;
      ex_mem_d.store_data    = data2;
      ex_mem_d.write_reg     = reg_dst ? reg2 : reg1;
      ex_mem_d.branch        = branch;
      ex_mem_d.mem_write     = mem_write;
      ex_mem_d.mem_read      = mem_read;
      ex_mem_d.reg_write     = reg_write;
      ex_mem_d.mem_to_reg    = mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign branch_target_reg = ex_mem_q.branch_target;
  assign zero_reg          = ex_mem_q.zero;
  assign alu_result_reg    = ex_mem_q.alu_result;
  assign store_data_reg    = ex_mem_q.store_data;
  assign write_reg_reg     = ex_mem_q.write_reg;
  assign branch_reg        = ex_mem_q.branch;
  assign mem_write_reg     = ex_mem_q.mem_write;
  assign mem_read_reg      = ex_mem_q.mem_read;
  assign reg_write_reg     = ex_mem_q.reg_write;
  assign mem_to_reg_reg    = ex_mem_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, branch target, multiply,
// divide corner cases, flush abort and reset during a multiply.
module tb_ex_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_op;
  logic        reg_dst, alu_src;
  logic        branch, mem_write, mem_read, reg_write, mem_to_reg;
  logic [7:0]  pc_next;
  logic [31:0] data1, data2, sign_extend;
  logic [4:0]  reg1, reg2;
  logic        flush_ex;
  logic        stall_ex;
  logic [7:0]  branch_target_reg;
  logic        zero_reg;
  logic [31:0] alu_result_reg, store_data_reg;
  logic [4:0]  write_reg_reg;
  logic        branch_reg, mem_write_reg, mem_read_reg;
  logic        reg_write_reg, mem_to_reg_reg;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk               (clk),
    .reset             (reset),
    .alu_op            (alu_op),
    .reg_dst           (reg_dst),
    .alu_src           (alu_src),
    .branch            (branch),
    .mem_write         (mem_write),
    .mem_read          (mem_read),
    .reg_write         (reg_write),
    .mem_to_reg        (mem_to_reg),
    .pc_next           (pc_next),
    .data1             (data1),
    .data2             (data2),
    .sign_extend       (sign_extend),
    .reg1              (reg1),
    .reg2              (reg2),
    .flush_ex          (flush_ex),
    .stall_ex          (stall_ex),
    .branch_target_reg (branch_target_reg),
    .zero_reg          (zero_reg),
    .alu_result_reg    (alu_result_reg),
    .store_data_reg    (store_data_reg),
    .write_reg_reg     (write_reg_reg),
    .branch_reg        (branch_reg),
    .mem_write_reg     (mem_write_reg),
    .mem_read_reg      (mem_read_reg),
    .reg_write_reg     (reg_write_reg),
    .mem_to_reg_reg    (mem_to_reg_reg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] se,
                       input logic src, input logic ctl);
    alu_op = op; data1 = d1; data2 = d2; sign_extend = se;
    alu_src = src; branch = ctl; mem_write = ctl; mem_read = ctl;
    reg_write = ctl; mem_to_reg = ctl;
    reg_dst = 1'b1; reg1 = 5'd3; reg2 = 5'd9; pc_next = 8'h10;
  endtask

  // runs one mul/div op to retirement; reports stall cycles and bubbles
  task automatic run_md(input logic [5:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, output int stalls,
                        output bit bub_ok);
    drive(op, d1, d2, 32'h0000_0044, 1'b0, 1'b1);
    stalls = 0;
    bub_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall_ex) break;
      stalls++;
      tick();
      if (alu_result_reg !== 32'd0 || reg_write_reg !== 1'b0 ||
          branch_reg !== 1'b0 || mem_write_reg !== 1'b0 ||
          write_reg_reg !== 5'd0 || branch_target_reg !== 8'd0)
        bub_ok = 1'b0;
    end
    tick();
    if (reg_write_reg !== 1'b0 || alu_result_reg !== 32'd0) bub_ok = 1'b0;
  endtask

  task automatic read_hilo(output logic [31:0] lo_v, output logic [31:0] hi_v);
    drive(ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    lo_v = alu_result_reg;
    drive(ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    hi_v = alu_result_reg;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush_ex = 1'b0;
    drive(ALU_MULT, 32'd3, 32'd4, 32'hFF, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (stall_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b want 0", stall_ex);
    end
    tick();
    n_checks++;
    if ({branch_target_reg, zero_reg, alu_result_reg, store_data_reg,
         write_reg_reg, branch_reg, mem_write_reg, mem_read_reg,
         reg_write_reg, mem_to_reg_reg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: alu=%h tgt=%h wr=%h not all zero",
               alu_result_reg, branch_target_reg, write_reg_reg);
    end
    drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_sub();
    drive(ALU_ADD, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (alu_result_reg !== 32'd0) begin
      n_fail++;
      $display("FAIL add_latency: got %h want 0 before edge", alu_result_reg);
    end
    tick();
    n_checks++;
    if (alu_result_reg !== 32'd12 || zero_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL add: got %h z=%b want 0000000c z=0", alu_result_reg, zero_reg);
    end
    n_checks++;
    if (write_reg_reg !== 5'd9 || store_data_reg !== 32'd5 ||
        reg_write_reg !== 1'b1 || mem_to_reg_reg !== 1'b1) begin
      n_fail++;
      $display("FAIL add_fields: wr=%0d sd=%h rw=%b m2r=%b want 9 5 1 1",
               write_reg_reg, store_data_reg, reg_write_reg, mem_to_reg_reg);
    end
    drive(ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (alu_result_reg !== 32'd0 || zero_reg !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero: got %h z=%b want 0 z=1", alu_result_reg, zero_reg);
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  op;
    logic [31:0] d1, d2, se, exp;
    logic        src;
    for (int i = 0; i < 11; i++) begin
      src = 1'b0; se = 32'd0; d1 = 32'd0; d2 = 32'd0;
      case (i)
        0:  begin op = ALU_AND; d1 = 32'hF0F0; d2 = 32'hFF00; exp = 32'hF000; end
        1:  begin op = ALU_OR;  d1 = 32'hF0F0; d2 = 32'hFF00; exp = 32'hFFF0; end
        2:  begin op = ALU_XOR; d1 = 32'hF0F0; d2 = 32'hFF00; exp = 32'h0FF0; end
        3:  begin op = ALU_NOR; exp = 32'hFFFF_FFFF; end
        4:  begin op = ALU_SLT; d1 = 32'hFFFF_FFFF; d2 = 32'd1; exp = 32'd1; end
        5:  begin op = ALU_SLT; d1 = 32'd1; d2 = 32'hFFFF_FFFF; exp = 32'd0; end
        6:  begin op = ALU_SLL; d2 = 32'd1; se = 32'h100; exp = 32'h10; end
        7:  begin op = ALU_SRL; d2 = 32'h8000_0000; se = 32'h7C0; exp = 32'd1; end
        8:  begin op = ALU_ADD; d1 = 32'd10; se = 32'hFFFF_FFFE; src = 1'b1; exp = 32'd8; end
        9:  begin op = ALU_ADD; d1 = 32'hFFFF_FFFF; d2 = 32'd2; exp = 32'd1; end
        default: begin op = ALU_SUB; d2 = 32'd1; exp = 32'hFFFF_FFFF; end
      endcase
      drive(op, d1, d2, se, src, 1'b1);
      tick();
      n_checks++;
      if (alu_result_reg !== exp || zero_reg !== (exp == 32'd0)) begin
        n_fail++;
        $display("FAIL alu_vec%0d: got %h z=%b want %h", i,
                 alu_result_reg, zero_reg, exp);
      end
    end
  endtask

  task automatic test_branch();
    drive(ALU_SUB, 32'd4, 32'd4, 32'd3, 1'b0, 1'b1);
    pc_next = 8'hFE;
    reg_dst = 1'b0;
    tick();
    n_checks++;
    if (branch_target_reg !== 8'h01 || branch_reg !== 1'b1 || zero_reg !== 1'b1) begin
      n_fail++;
      $display("FAIL branch: tgt=%h br=%b z=%b want 01 1 1",
               branch_target_reg, branch_reg, zero_reg);
    end
    n_checks++;
    if (write_reg_reg !== 5'd3 || mem_write_reg !== 1'b1 || mem_read_reg !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_dst_rt: wr=%0d mw=%b mr=%b want 3 1 1",
               write_reg_reg, mem_write_reg, mem_read_reg);
    end
  endtask

  task automatic test_mult();
    int stalls;
    bit bub_ok;
    logic [31:0] lo_v, hi_v;
    run_md(ALU_MULT, 32'hFFFF_FFFD, 32'd7, stalls, bub_ok);
    n_checks++;
    if (stalls !== 33) begin
      n_fail++;
      $display("FAIL mult_stall_len: got %0d want 33", stalls);
    end
    n_checks++;
    if (!bub_ok) begin
      n_fail++;
      $display("FAIL mult_bubbles: got non-bubble want bubble");
    end
    read_hilo(lo_v, hi_v);
    n_checks++;
    if (lo_v !== 32'hFFFF_FFEB || hi_v !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL mult_hilo: got lo=%h hi=%h want ffffffeb ffffffff", lo_v, hi_v);
    end
    run_md(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, bub_ok);
    read_hilo(lo_v, hi_v);
    n_checks++;
    if (lo_v !== 32'h0000_0001 || hi_v !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL multu_hilo: got lo=%h hi=%h want 00000001 fffffffe", lo_v, hi_v);
    end
  endtask

  task automatic test_div();
    int stalls;
    bit bub_ok;
    logic [31:0] lo_v, hi_v;
    logic [31:0] d1, d2, elo, ehi;
    logic [5:0]  op;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin op = ALU_DIV;  d1 = 32'd7; d2 = 32'd0;
                 elo = 32'hFFFF_FFFF; ehi = 32'd7; end
        1: begin op = ALU_DIV;  d1 = 32'hFFFF_FFF9; d2 = 32'd2;
                 elo = 32'hFFFF_FFFD; ehi = 32'hFFFF_FFFF; end
        2: begin op = ALU_DIVU; d1 = 32'h8000_0000; d2 = 32'd2;
                 elo = 32'h4000_0000; ehi = 32'd0; end
        3: begin op = ALU_DIV;  d1 = 32'h8000_0000; d2 = 32'hFFFF_FFFF;
                 elo = 32'h8000_0000; ehi = 32'd0; end
        default: begin op = ALU_DIVU; d1 = 32'hFFFF_FFFF; d2 = 32'd10;
                 elo = 32'h1999_9999; ehi = 32'd5; end
      endcase
      run_md(op, d1, d2, stalls, bub_ok);
      n_checks++;
      if (stalls !== 33 || !bub_ok) begin
        n_fail++;
        $display("FAIL div%0d_stall: got %0d bub_ok=%b want 33 1", i, stalls, bub_ok);
      end
      read_hilo(lo_v, hi_v);
      n_checks++;
      if (lo_v !== elo || hi_v !== ehi) begin
        n_fail++;
        $display("FAIL div%0d_hilo: got lo=%h hi=%h want %h %h",
                 i, lo_v, hi_v, elo, ehi);
      end
    end
  endtask

  task automatic test_flush();
    int stalls;
    bit bub_ok;
    logic [31:0] lo_v, hi_v;
    run_md(ALU_DIV, 32'hFFFF_FFF9, 32'd2, stalls, bub_ok);
    drive(ALU_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
    tick();
    repeat (10) tick();
    flush_ex = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stall_ex !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy_stall: got %b want 1", stall_ex);
    end
    tick();
    flush_ex = 1'b0;
    n_checks++;
    if (alu_result_reg !== 32'd0 || reg_write_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: got %h rw=%b want 0 0", alu_result_reg, reg_write_reg);
    end
    drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (stall_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_abort: stall got %b want 0", stall_ex);
    end
    tick();
    n_checks++;
    if (alu_result_reg !== 32'd3) begin
      n_fail++;
      $display("FAIL after_flush_add: got %h want 3", alu_result_reg);
    end
    read_hilo(lo_v, hi_v);
    n_checks++;
    if (lo_v !== 32'hFFFF_FFFD || hi_v !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL flush_hilo: got lo=%h hi=%h want fffffffd ffffffff", lo_v, hi_v);
    end
    drive(ALU_ADD, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1);
    flush_ex = 1'b1;
    tick();
    flush_ex = 1'b0;
    n_checks++;
    if (alu_result_reg !== 32'd0 || reg_write_reg !== 1'b0 || mem_read_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_alu: got %h rw=%b want 0 0", alu_result_reg, reg_write_reg);
    end
  endtask

  task automatic test_reset_mid_mult();
    logic [31:0] lo_v, hi_v;
    drive(ALU_MULT, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1);
    tick();
    repeat (5) tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (stall_ex !== 1'b0 || alu_result_reg !== 32'd0 || reg_write_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: stall=%b alu=%h want 0 0", stall_ex, alu_result_reg);
    end
    tick();
    drive(ALU_ADD, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    n_checks++;
    if (alu_result_reg !== 32'd12 || zero_reg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_add: got %h z=%b want 0000000c 0", alu_result_reg, zero_reg);
    end
    read_hilo(lo_v, hi_v);
    n_checks++;
    if (lo_v !== 32'd0 || hi_v !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hilo: got lo=%h hi=%h want 0 0", lo_v, hi_v);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_alu_ops();
    test_branch();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid_mult();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
